// File: rtl/gcd_operand_queue.sv
// gcd_operand_queue: operand-pair FIFO upstream of the GCD top.
// Ports:
//   sys_clk, sys_rst            clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b source side (push = in_valid & in_ready)
//   operand_A/operand_B         head-of-queue pair, first-word fall-through
//   input_ready/input_available GCD side (pop = input_ready & input_available)
//   level                       pairs currently stored
//   drop_cnt                    dropped (0,0) pairs, only with GCD_OPQ_ZERO_DROP_EN
// Optional feature macro: GCD_OPQ_ZERO_DROP_EN
module gcd_operand_queue #(
    parameter int width = 8,
    parameter int DEPTH = 4
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [width-1:0]         in_a,
    input  logic [width-1:0]         in_b,
    output logic [width-1:0]         operand_A,
    output logic [width-1:0]         operand_B,
    output logic                     input_ready,
    input  logic                     input_available,
`ifdef GCD_OPQ_ZERO_DROP_EN
    output logic [7:0]               drop_cnt,
`endif
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    // Occupancy view, derived from level only.
    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } occ_t;

    occ_t occ;

    logic [2*width-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               push;
    logic               store;
    logic               pop;
    logic [2*width-1:0] head;

    always_comb begin
        occ = PARTIAL;
        if (level == '0) begin
            occ = EMPTY;
        end else if (level == FULL_LVL) begin
            occ = FULL;
        end
    end

    // in_ready depends only on registered state and reset, so a pop in the
    // same cycle never frees a slot for a push into a full queue.
    assign in_ready    = (occ != FULL) && !sys_rst;
    assign input_ready = (occ != EMPTY);

    assign push = in_valid && in_ready;
    assign pop  = input_ready && input_available;

`ifdef GCD_OPQ_ZERO_DROP_EN
    logic zero_pair;
    assign zero_pair = (in_a == '0) && (in_b == '0);
    // A (0,0) pair completes the handshake but is never written.
    assign store = push && !zero_pair;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            drop_cnt <= '0;
        end else if (push && zero_pair && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`else
    assign store = push;
`endif

    assign head      = mem[rd_ptr];
    assign operand_A = head[2*width-1:width];
    assign operand_B = head[width-1:0];

    // Storage is intentionally left out of reset.
    always_ff @(posedge sys_clk) begin
        if (store) begin
            mem[wr_ptr] <= {in_a, in_b};
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({store, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule
